// File: rtl/mem_responder.sv
// mem_responder: single-port data memory answering hart load/store requests.
// One request is accepted at a time through a valid/ready handshake.
// WAIT_STATES idle cycles follow acceptance, then a one-cycle response.
// Stores are byte-lane masked. Misaligned, out-of-range and illegal-width
// requests raise resp_error and leave the memory unchanged.
module mem_responder #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] addr,
   input  logic            wenable,
   input  logic [1:0]      wwidth,
   input  logic [XLEN-1:0] wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_error
);
   localparam int AW    = $clog2(DEPTH_WORDS);
   localparam int LANES = XLEN / 8;
   localparam logic [XLEN-3:0] DEPTH_LIM = (XLEN-2)'(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state_reg, state_next;
   logic [3:0]      cnt_reg, cnt_next;
   logic            accept;

   // request captured on the acceptance edge; later input changes are ignored
   logic [XLEN-1:0] addr_reg;
   logic [XLEN-1:0] wdata_reg;
   logic            wenable_reg;
   logic [1:0]      wwidth_reg;

   logic [XLEN-1:0] mem [DEPTH_WORDS];
   logic [XLEN-1:0] rdata_reg;
   logic [AW-1:0]   rd_idx;
   logic [AW-1:0]   wr_idx;

   logic            range_err;
   logic            align_err;
   logic            err;
   logic            commit;
   logic [LANES-1:0] lane_mask;
   logic [XLEN-1:0] lane_data;

   // next-state, counter and handshake decode
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      req_ready  = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept     = 1'b1;
               cnt_next   = 4'(WAIT_STATES);
               state_next = (WAIT_STATES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // nothing is accepted or offered while reset is held
      if (!rst_n) begin
         req_ready = 1'b0;
         accept    = 1'b0;
      end
   end

   // state and wait counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // latch the request fields on acceptance
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_reg    <= addr;
         wdata_reg   <= wdata;
         wenable_reg <= wenable;
         wwidth_reg  <= wwidth;
      end
   end

   // loads never fault on alignment; the full aligned word is returned
   assign range_err = (addr_reg[XLEN-1:2] >= DEPTH_LIM);
   assign align_err = wenable_reg &&
                      ((wwidth_reg == 2'd3) ||
                       ((wwidth_reg == 2'd1) && addr_reg[0]) ||
                       ((wwidth_reg == 2'd2) && (addr_reg[1:0] != 2'd0)));
   assign err       = range_err || align_err;

   // a reset arriving in RESP cancels the store
   assign commit = (state_reg == RESP) && rst_n && wenable_reg && !err;

   // lane enables and the byte routed onto each lane
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign lane_mask[gi] = (wwidth_reg == 2'd2) ||
                                ((wwidth_reg == 2'd1) && (addr_reg[1] == LANE[1])) ||
                                ((wwidth_reg == 2'd0) && (addr_reg[1:0] == LANE));
         assign lane_data[8*gi +: 8] = (wwidth_reg == 2'd0) ? wdata_reg[7:0] :
                                       (wwidth_reg == 2'd1) ? wdata_reg[8*(gi%2) +: 8] :
                                                              wdata_reg[8*gi +: 8];
      end
   endgenerate

   // In IDLE the read port follows the incoming address, so a zero-wait
   // request has its word registered on the same edge that accepts it.
   assign rd_idx = (state_reg == IDLE) ? addr[AW+1:2] : addr_reg[AW+1:2];
   assign wr_idx = addr_reg[AW+1:2];

   // byte-enabled write port and registered read port
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < LANES; b++) begin
            if (lane_mask[b]) begin
               mem[wr_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
         end
      end
      rdata_reg <= mem[rd_idx];
   end

   assign resp_valid = (state_reg == RESP) && rst_n;
   assign resp_error = resp_valid && err;
   assign resp_rdata = (resp_valid && !wenable_reg && !err) ? rdata_reg : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed test-plan steps plus randomized traffic
// checked against a byte-level reference memory kept in an associative array.
module tb_mem_responder;
   localparam int WS = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v1, v0, v3;
   logic        rdy1, rdy0, rdy3;
   logic [31:0] addr_i, wd_i;
   logic        wen_i;
   logic [1:0]  ww_i;
   logic        rv1, rv0, rv3;
   logic [31:0] rd1, rd0, rd3;
   logic        er1, er0, er3;

   int total = 0;
   int bad   = 0;

   // reference memory: word index -> word value, only for words fully known
   logic [31:0] mdl [int unsigned];

   always #5 clk = ~clk;

   mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
      .addr(addr_i), .wenable(wen_i), .wwidth(ww_i), .wdata(wd_i),
      .resp_valid(rv1), .resp_rdata(rd1), .resp_error(er1));

   mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0),
      .addr(addr_i), .wenable(wen_i), .wwidth(ww_i), .wdata(wd_i),
      .resp_valid(rv0), .resp_rdata(rd0), .resp_error(er0));

   mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
      .addr(addr_i), .wenable(wen_i), .wwidth(ww_i), .wdata(wd_i),
      .resp_valid(rv3), .resp_rdata(rd3), .resp_error(er3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err(input logic wen, input logic [31:0] a, input logic [1:0] w);
      logic e;
      e = 1'b0;
      if ((a >> 2) >= 32'd1024) e = 1'b1;
      else if (wen) begin
         case (w)
            2'd0:    e = 1'b0;
            2'd1:    e = a[0];
            2'd2:    e = (a[1:0] != 2'd0);
            default: e = 1'b1;
         endcase
      end
      return e;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
      int unsigned idx;
      logic [31:0] old, m;
      int sh;
      idx = a >> 2;
      if (w == 2'd2) begin
         mdl[idx] = d;
      end else if (mdl.exists(idx)) begin
         old = mdl[idx];
         if (w == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            m  = 32'hFF << sh;
            mdl[idx] = (old & ~m) | ((d & 32'hFF) << sh);
         end else begin
            sh = 16 * int'(a[1]);
            m  = 32'hFFFF << sh;
            mdl[idx] = (old & ~m) | ((d & 32'hFFFF) << sh);
         end
      end
   endtask

   // one request on u_dut; called and returns on a falling edge
   task automatic txn(input string tag, input logic wen, input logic [31:0] a,
                      input logic [1:0] w, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
      int lat;
      bit seen;
      check({tag, ".ready"}, {31'd0, rdy1}, 32'd1);
      v1 = 1'b1; wen_i = wen; addr_i = a; ww_i = w; wd_i = d;
      @(posedge clk);
      #1;
      v1 = 1'b0;
      addr_i = $urandom; wd_i = $urandom; wen_i = 1'($urandom); ww_i = 2'($urandom);
      seen = 0; lat = 0; rd = '0; er = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         if (rv1) begin
            seen = 1; lat = k; rd = rd1; er = er1;
            check({tag, ".busy"}, {31'd0, rdy1}, 32'd0);
         end else begin
            check({tag, ".wait_ready"}, {31'd0, rdy1}, 32'd0);
         end
      end
      check({tag, ".latency"}, 32'(lat), 32'(WS + 1));
      @(negedge clk);
      check({tag, ".pulse"}, {31'd0, rv1}, 32'd0);
   endtask

   task automatic op(input string tag, input logic wen, input logic [31:0] a,
                     input logic [1:0] w, input logic [31:0] d, output logic [31:0] rd);
      logic er, e_err;
      int unsigned idx;
      idx   = a >> 2;
      e_err = model_err(wen, a, w);
      txn(tag, wen, a, w, d, rd, er);
      check({tag, ".err"}, {31'd0, er}, {31'd0, e_err});
      if (e_err || wen) check({tag, ".rdata"}, rd, 32'd0);
      else if (mdl.exists(idx)) check({tag, ".rdata"}, rd, mdl[idx]);
      if (wen && !e_err) model_store(a, w, d);
      $display("txn %s wen=%0d addr=%h w=%0d wd=%h -> rdata=%h err=%0d",
               tag, wen, a, w, d, rd, er);
   endtask

   initial begin
      logic [31:0] rd, a, d;
      logic        wen;
      logic [1:0]  w;

      rst_n = 1'b0; v1 = 1'b0; v0 = 1'b0; v3 = 1'b0;
      addr_i = '0; wd_i = '0; wen_i = 1'b0; ww_i = 2'd0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.ready", {31'd0, rdy1}, 32'd0);
      check("rst.valid", {31'd0, rv1}, 32'd0);
      check("rst.rdata", rd1, 32'd0);
      check("rst.error", {31'd0, er1}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst.ready_after", {31'd0, rdy1}, 32'd1);
      check("rst.ready_after0", {31'd0, rdy0}, 32'd1);
      @(negedge clk);

      // word round trip
      op("rt.store", 1'b1, 32'h10, 2'd2, 32'hDEADBEEF, rd);
      op("rt.load", 1'b0, 32'h10, 2'd0, 32'h0, rd);
      check("rt.lit", rd, 32'hDEADBEEF);

      // byte / halfword merge
      op("mg.word", 1'b1, 32'h20, 2'd2, 32'h11223344, rd);
      op("mg.byte", 1'b1, 32'h21, 2'd0, 32'hFFFF_FFAA, rd);
      op("mg.half", 1'b1, 32'h22, 2'd1, 32'h1234_BBCC, rd);
      op("mg.load", 1'b0, 32'h20, 2'd0, 32'h0, rd);
      check("mg.lit", rd, 32'hBBCCAA44);

      // misaligned and illegal-width stores
      op("ma.init", 1'b1, 32'h30, 2'd2, 32'hCAFEF00D, rd);
      op("ma.half", 1'b1, 32'h31, 2'd1, 32'h0000_1111, rd);
      op("ma.word", 1'b1, 32'h32, 2'd2, 32'h2222_2222, rd);
      op("ma.w3", 1'b1, 32'h30, 2'd3, 32'h3333_3333, rd);
      op("ma.load", 1'b0, 32'h30, 2'd0, 32'h0, rd);
      check("ma.lit", rd, 32'hCAFEF00D);

      // out of range, no aliasing onto word 0
      op("oor.init", 1'b1, 32'h0, 2'd2, 32'h0BAD_CAFE, rd);
      op("oor.load", 1'b0, 32'h1000, 2'd0, 32'h0, rd);
      op("oor.store", 1'b1, 32'h1000, 2'd2, 32'h5A5A_5A5A, rd);
      op("oor.check", 1'b0, 32'h0, 2'd0, 32'h0, rd);
      check("oor.lit", rd, 32'h0BAD_CAFE);

      // reset during WAIT drops the pending store
      op("mr.init", 1'b1, 32'h40, 2'd2, 32'h12345678, rd);
      v1 = 1'b1; wen_i = 1'b1; addr_i = 32'h40; ww_i = 2'd0; wd_i = 32'h55;
      @(posedge clk);
      #1;
      v1 = 1'b0;
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("mr.valid_in_rst", {31'd0, rv1}, 32'd0);
         check("mr.ready_in_rst", {31'd0, rdy1}, 32'd0);
      end
      rst_n = 1'b1;
      #1;
      check("mr.ready_after", {31'd0, rdy1}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("mr.no_valid", {31'd0, rv1}, 32'd0);
      end
      op("mr.load", 1'b0, 32'h40, 2'd0, 32'h0, rd);
      check("mr.lit", rd, 32'h12345678);

      // randomized traffic on a small window plus some out-of-range addresses
      for (int i = 0; i < 8; i++) begin
         op($sformatf("ri.%0d", i), 1'b1, 32'(i << 2), 2'd2, $urandom, rd);
      end
      for (int i = 0; i < 150; i++) begin
         wen = 1'($urandom);
         w   = 2'($urandom);
         d   = $urandom;
         case ($urandom_range(0, 9))
            0:       a = 32'h1000 + ($urandom_range(0, 255) << 2) + 32'($urandom_range(0, 3));
            1:       a = $urandom | 32'h8000_0000;
            default: a = ($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
         endcase
         op($sformatf("rnd.%0d", i), wen, a, w, d, rd);
      end

      // handshake with request held: zero and three wait states
      addr_i = 32'h0; wen_i = 1'b0; ww_i = 2'd0; wd_i = 32'h0;
      v0 = 1'b1; v3 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         check($sformatf("hs0.ready.%0d", k), {31'd0, rdy0}, 32'((k % 2) == 0));
         check($sformatf("hs0.valid.%0d", k), {31'd0, rv0}, 32'((k % 2) == 1));
         check($sformatf("hs3.ready.%0d", k), {31'd0, rdy3}, 32'((k % 5) == 0));
         check($sformatf("hs3.valid.%0d", k), {31'd0, rv3}, 32'((k % 5) == 4));
         @(negedge clk);
      end
      v0 = 1'b0; v3 = 1'b0;
      $display("handshake window done");
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
